// File: rtl/poisson_pkg.sv
// rtl/poisson_pkg.sv - shared types and constants for the Poisson neuron RNG path
//
// Purpose: arbiter FSM state encoding and the random word width shared by
//          the lfsr, the arbiter and the neuron instances.
// Ports:   none (package).
package poisson_pkg;

  localparam int RNG_REG_LEN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    GRANT = 2'd2
  } rng_arb_state_t;

endpackage

// File: rtl/poisson_rng_arbiter_rr_pick.sv
// rtl/poisson_rng_arbiter_rr_pick.sv - combinational round-robin selector
//
// Purpose: picks the first asserted request at or above ptr, wrapping mod N_REQ.
// Ports:
//   req  in  N_REQ       request vector
//   ptr  in  clog2(N_REQ) highest-priority index for this pick
//   gnt  out N_REQ       one-hot winner (all zero when no request)
//   idx  out clog2(N_REQ) winner index (zero when no request)
//   any  out 1           at least one request present
module rr_pick #(
  parameter int N_REQ = 8,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             any
);

  always_comb begin
    logic [PW-1:0] cand;
    cand = '0;
    idx  = '0;
    any  = 1'b0;
    // Walk upward from ptr; the first hit wins and later hits are ignored.
    for (int i = 0; i < N_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/poisson_rng_arbiter.sv
// rtl/poisson_rng_arbiter.sv - shares one LFSR among N_REQ Poisson neuron units
//
// Purpose: steps the external LFSR SKIP times per grant, then hands the word
//          to one requester chosen round-robin. Optional grant statistics are
//          enabled by defining RNG_ARB_STATS_EN.
// Ports:
//   clk        in  1        clock, rising edge
//   reset      in  1        asynchronous active-low reset
//   en         in  1        global enable; low aborts stepping, blocks new arbitration
//   req        in  N_REQ    per-neuron request, held until granted
//   gnt        out N_REQ    one-hot grant, one cycle wide
//   rnd_valid  out 1        high in the grant cycle
//   rnd_data   out REG_LEN  random word, zero unless rnd_valid
//   lfsr_en    out 1        LFSR step enable
//   lfsr_out   in  REG_LEN  LFSR output word
//   grant_cnt  out 32       saturating grant count (RNG_ARB_STATS_EN only)
module poisson_rng_arbiter
  import poisson_pkg::*;
#(
  parameter int N_REQ   = 8,
  parameter int REG_LEN = RNG_REG_LEN,
  parameter int SKIP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   gnt,
  output logic               rnd_valid,
  output logic [REG_LEN-1:0] rnd_data,
  output logic               lfsr_en,
  input  logic [REG_LEN-1:0] lfsr_out
`ifdef RNG_ARB_STATS_EN
  ,
  output logic [31:0]        grant_cnt
`endif
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam logic [CW-1:0] STEP_LOAD = CW'(SKIP - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(N_REQ - 1);

  rng_arb_state_t state, next_state;
  logic [PW-1:0]  ptr;
  logic [CW-1:0]  step_cnt;

  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (en && |req) next_state = STEP;
      end
      STEP: begin
        if (!en || !(|req))     next_state = IDLE;
        else if (step_cnt == '0) next_state = GRANT;
        else                     next_state = STEP;
      end
      GRANT: begin
        // A grant still occurs with en low; en only decides whether to continue.
        if (pick_any && en && |(req & ~pick_gnt)) next_state = STEP;
        else                                      next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Step counter: reload on every entry into STEP, count down while stepping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt <= '0;
    end else if (next_state == STEP && state != STEP) begin
      step_cnt <= STEP_LOAD;
    end else if (state == STEP && next_state == STEP) begin
      step_cnt <= step_cnt - CW'(1);
    end
  end

  // Round-robin pointer moves only on an actual grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (state == GRANT && pick_any) begin
      ptr <= (pick_idx == LAST_IDX) ? '0 : pick_idx + PW'(1);
    end
  end

  // Outputs are combinational from state so reset clears them immediately.
  always_comb begin
    lfsr_en   = (state == STEP) && en;
    gnt       = (state == GRANT) ? pick_gnt : '0;
    rnd_valid = (state == GRANT) && pick_any;
    rnd_data  = rnd_valid ? lfsr_out : '0;
  end

`ifdef RNG_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
    end else if (rnd_valid && grant_cnt != 32'hFFFF_FFFF) begin
      grant_cnt <= grant_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_poisson_rng_arbiter.sv
// tb/tb_poisson_rng_arbiter.sv - self-checking bench for poisson_rng_arbiter
module tb_poisson_rng_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en, en4;
  logic [7:0]  req, req4, gnt, gnt4;
  logic        valid, valid4, lfsr_en, lfsr_en4;
  logic [15:0] data, data4, lfsr, lfsr4;
`ifdef RNG_ARB_STATS_EN
  logic [31:0] grant_cnt, grant_cnt4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  poisson_rng_arbiter #(.N_REQ(8), .REG_LEN(16), .SKIP(1)) u_dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .gnt(gnt),
    .rnd_valid(valid), .rnd_data(data), .lfsr_en(lfsr_en), .lfsr_out(lfsr)
`ifdef RNG_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  poisson_rng_arbiter #(.N_REQ(8), .REG_LEN(16), .SKIP(4)) u_dut4 (
    .clk(clk), .reset(reset), .en(en4), .req(req4), .gnt(gnt4),
    .rnd_valid(valid4), .rnd_data(data4), .lfsr_en(lfsr_en4), .lfsr_out(lfsr4)
`ifdef RNG_ARB_STATS_EN
    , .grant_cnt(grant_cnt4)
`endif
  );

  // External LFSRs (x^16+x^14+x^13+x^11+1, right shift, seed 1)
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  function automatic logic [15:0] lfsr_after(input int k);
    logic [15:0] x;
    x = 16'h0001;
    for (int i = 0; i < k; i++) x = lfsr_next(x);
    return x;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= 16'h0001;
    else if (lfsr_en) lfsr <= lfsr_next(lfsr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr4 <= 16'h0001;
    else if (lfsr_en4) lfsr4 <= lfsr_next(lfsr4);
  end

  typedef struct {
    logic [7:0]  req;
    logic        en;
    logic [7:0]  gnt;
    logic        valid;
    logic        lfsr_en;
    logic [15:0] data;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] r, input logic e, input logic [7:0] g,
                      input logic v, input logic le, input logic [15:0] d);
    vec_t x;
    x.req = r; x.en = e; x.gnt = g; x.valid = v; x.lfsr_en = le; x.data = d;
    vq.push_back(x);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      req = vq[i].req;
      en  = vq[i].en;
      #1;
      check($sformatf("%s[%0d].gnt", tag, i), {24'h0, gnt}, {24'h0, vq[i].gnt});
      check($sformatf("%s[%0d].rnd_valid", tag, i), {31'h0, valid}, {31'h0, vq[i].valid});
      check($sformatf("%s[%0d].lfsr_en", tag, i), {31'h0, lfsr_en}, {31'h0, vq[i].lfsr_en});
      check($sformatf("%s[%0d].rnd_data", tag, i), {16'h0, data}, {16'h0, vq[i].data});
    end
    vq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0; en = 1'b0; req4 = '0; en4 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs low even with requests pending
    req = 8'hFF; en = 1'b1; req4 = 8'hFF; en4 = 1'b1;
    #3;
    check("reset.gnt", {24'h0, gnt}, 32'h0);
    check("reset.rnd_valid", {31'h0, valid}, 32'h0);
    check("reset.rnd_data", {16'h0, data}, 32'h0);
    check("reset.lfsr_en", {31'h0, lfsr_en}, 32'h0);
    check("reset.gnt4", {24'h0, gnt4}, 32'h0);
    check("reset.lfsr_en4", {31'h0, lfsr_en4}, 32'h0);
`ifdef RNG_ARB_STATS_EN
    check("reset.grant_cnt", grant_cnt, 32'h0);
`endif
    @(negedge clk);
    req = '0; en = 1'b0; req4 = '0; en4 = 1'b0;
    reset = 1'b1;
    @(negedge clk); #1;
    check("post_reset.gnt", {24'h0, gnt}, 32'h0);
    check("post_reset.rnd_valid", {31'h0, valid}, 32'h0);
    check("post_reset.lfsr_en", {31'h0, lfsr_en}, 32'h0);

    // Single request, then a request that vanishes during STEP (ptr stays at 3)
    push(8'h04, 1, 8'h00, 0, 0, 16'h0000);
    push(8'h04, 1, 8'h00, 0, 1, 16'h0000);
    push(8'h04, 1, 8'h04, 1, 0, 16'h8000);
    push(8'h00, 1, 8'h00, 0, 0, 16'h0000);
    push(8'h02, 1, 8'h00, 0, 0, 16'h0000);
    push(8'h00, 1, 8'h00, 0, 1, 16'h0000);
    push(8'h00, 1, 8'h00, 0, 0, 16'h0000);
    push(8'hFF, 1, 8'h00, 0, 0, 16'h0000);
    push(8'hFF, 1, 8'h00, 0, 1, 16'h0000);
    push(8'hFF, 1, 8'h08, 1, 0, lfsr_after(3));
    push(8'h00, 1, 8'h00, 0, 1, 16'h0000);
    push(8'h00, 1, 8'h00, 0, 0, 16'h0000);
    run_vecs("single");

    // Rotation with all requests held: 0..7 then 0, one grant every 2 cycles
    do_reset();
    push(8'hFF, 1, 8'h00, 0, 0, 16'h0000);
    for (int k = 0; k < 9; k++) begin
      push(8'hFF, 1, 8'h00, 0, 1, 16'h0000);
      push(8'hFF, 1, 8'(1 << (k % 8)), 1, 0, lfsr_after(k + 1));
    end
    run_vecs("rotate");
`ifdef RNG_ARB_STATS_EN
    @(negedge clk); #1;
    check("rotate.grant_cnt", grant_cnt, 32'd9);
`endif

    // Enable abort on the SKIP=4 instance
    do_reset();
    @(negedge clk); req4 = 8'h01; en4 = 1'b1; #1;
    check("abort.idle_lfsr_en", {31'h0, lfsr_en4}, 32'h0);
    @(negedge clk); #1;
    check("abort.step1_lfsr_en", {31'h0, lfsr_en4}, 32'h1);
    @(negedge clk); en4 = 1'b0; #1;
    check("abort.step2_lfsr_en", {31'h0, lfsr_en4}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("abort.idle%0d_gnt", i), {24'h0, gnt4}, 32'h0);
      check($sformatf("abort.idle%0d_valid", i), {31'h0, valid4}, 32'h0);
      check($sformatf("abort.idle%0d_lfsr_en", i), {31'h0, lfsr_en4}, 32'h0);
    end
    check("abort.lfsr_steps", {16'h0, lfsr4}, {16'h0, lfsr_after(1)});
    @(negedge clk); en4 = 1'b1; #1;
    check("abort.reen_idle_lfsr_en", {31'h0, lfsr_en4}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check($sformatf("abort.step%0d_lfsr_en", i), {31'h0, lfsr_en4}, 32'h1);
      check($sformatf("abort.step%0d_gnt", i), {24'h0, gnt4}, 32'h0);
    end
    @(negedge clk); #1;
    check("abort.grant_gnt", {24'h0, gnt4}, 32'h01);
    check("abort.grant_valid", {31'h0, valid4}, 32'h1);
    check("abort.grant_data", {16'h0, data4}, {16'h0, lfsr_after(5)});
    check("abort.grant_lfsr_en", {31'h0, lfsr_en4}, 32'h0);
    @(negedge clk); req4 = '0; en4 = 1'b0;

    // Asynchronous reset between edges while in GRANT
    do_reset();
    @(negedge clk); req = 8'h01; en = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check("areset.pre_gnt", {24'h0, gnt}, 32'h01);
    check("areset.pre_valid", {31'h0, valid}, 32'h1);
    check("areset.pre_data", {16'h0, data}, 32'h8000);
    #1 reset = 1'b0;
    #1;
    check("areset.gnt", {24'h0, gnt}, 32'h0);
    check("areset.rnd_valid", {31'h0, valid}, 32'h0);
    check("areset.rnd_data", {16'h0, data}, 32'h0);
    check("areset.lfsr_en", {31'h0, lfsr_en}, 32'h0);
`ifdef RNG_ARB_STATS_EN
    check("areset.grant_cnt", grant_cnt, 32'h0);
`endif
    @(negedge clk); req = '0; en = 1'b0; reset = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
